// File: rtl/instr_fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module      : instr_fetch_queue
//  Description : Instruction fetch front end. Owns the fetch PC, issues
//                in-order word requests to a variable-latency instruction
//                memory (req/gnt + rvalid), buffers returned words with
//                their PCs in a DEPTH-entry FIFO and hands them to the
//                datapath over valid/ready. A redirect flushes the queue
//                and discards every response still in flight.
//  Options     : FETCH_BYPASS_EN - present a response combinationally
//                when the FIFO is empty instead of waiting one cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch_queue #(
    parameter int              PC_W     = 9,
    parameter int              INS_W    = 32,
    parameter int              DEPTH    = 4,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic             clk,
    input  logic             reset,
    output logic             imem_req,
    output logic [PC_W-1:0]  imem_addr,
    input  logic             imem_gnt,
    input  logic             imem_rvalid,
    input  logic [INS_W-1:0] imem_rdata,
    output logic             instr_valid,
    input  logic             instr_ready,
    output logic [INS_W-1:0] instr,
    output logic [PC_W-1:0]  instr_pc,
    input  logic             redirect,
    input  logic [PC_W-1:0]  redirect_pc,
    output logic [PC_W-1:0]  fetch_pc
);

    localparam int              c_PTR_W   = $clog2(DEPTH);
    localparam int              c_CNT_W   = c_PTR_W + 1;
    localparam logic [PC_W-1:0] c_PC_STEP = PC_W'(4);
    localparam logic [c_CNT_W:0] c_DEPTH  = (c_CNT_W + 1)'(DEPTH);

    logic [PC_W-1:0]    r_fetch_pc;
    logic [PC_W-1:0]    r_resp_pc;
    logic [c_PTR_W-1:0] r_wptr;
    logic [c_PTR_W-1:0] r_rptr;
    logic [c_CNT_W-1:0] r_count;
    logic [c_CNT_W-1:0] r_outstanding;
    logic [c_CNT_W-1:0] r_discard;
    logic [INS_W-1:0]   r_mem_instr [DEPTH];
    logic [PC_W-1:0]    r_mem_pc    [DEPTH];

    logic w_credit;
    logic w_grant;
    logic w_resp;
    logic w_drop;
    logic w_accept;
    logic w_fifo_nempty;
    logic w_bypass;
    logic w_pop;
    logic w_push;

    // Occupancy plus in-flight requests may never exceed the FIFO depth,
    // so every response is guaranteed a slot when it returns.
    assign w_credit      = ({1'b0, r_count} + {1'b0, r_outstanding}) < c_DEPTH;
    assign imem_req      = w_credit & ~redirect & ~reset;
    assign imem_addr     = r_fetch_pc;
    assign fetch_pc      = r_fetch_pc;
    assign w_grant       = imem_req & imem_gnt;

    // A response with nothing outstanding is a protocol error and ignored.
    assign w_resp        = imem_rvalid & (r_outstanding != '0);
    assign w_drop        = w_resp & (r_discard != '0);
    // The response arriving in a redirect cycle is stale as well.
    assign w_accept      = w_resp & ~w_drop & ~redirect;
    assign w_fifo_nempty = (r_count != '0);

`ifdef FETCH_BYPASS_EN
    assign w_bypass      = w_accept & ~w_fifo_nempty;
`else
    assign w_bypass      = 1'b0;
`endif

    assign instr_valid   = w_fifo_nempty | w_bypass;
    assign instr         = w_bypass ? imem_rdata : r_mem_instr[r_rptr];
    assign instr_pc      = w_bypass ? r_resp_pc  : r_mem_pc[r_rptr];

    assign w_pop         = w_fifo_nempty & instr_ready & ~redirect;
    // A bypassed word consumed in the same cycle never enters the FIFO.
    assign w_push        = w_accept & ~(w_bypass & instr_ready);

    // FIFO pointers and occupancy; a redirect empties the queue.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (redirect) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + c_PTR_W'(1);
            if (w_pop)  r_rptr <= r_rptr + c_PTR_W'(1);
            r_count <= r_count + c_CNT_W'(w_push) - c_CNT_W'(w_pop);
        end
    end

    // FIFO storage; contents are qualified by the occupancy count.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_instr[r_wptr] <= imem_rdata;
            r_mem_pc[r_wptr]    <= r_resp_pc;
        end
    end

    // In-flight request tracking; on redirect every unreturned response
    // (including ones already marked) becomes a discard.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_outstanding <= '0;
            r_discard     <= '0;
        end else begin
            r_outstanding <= r_outstanding + c_CNT_W'(w_grant) - c_CNT_W'(w_resp);
            if (redirect) begin
                r_discard <= r_outstanding - c_CNT_W'(w_resp);
            end else begin
                r_discard <= r_discard - c_CNT_W'(w_drop);
            end
        end
    end

    // Request PC and the PC tagged onto the next accepted response.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_fetch_pc <= RESET_PC;
            r_resp_pc  <= RESET_PC;
        end else if (redirect) begin
            r_fetch_pc <= redirect_pc;
            r_resp_pc  <= redirect_pc;
        end else begin
            if (w_grant)  r_fetch_pc <= r_fetch_pc + c_PC_STEP;
            if (w_accept) r_resp_pc  <= r_resp_pc + c_PC_STEP;
        end
    end

`ifndef SYNTHESIS
    // Responses must only arrive for requests that are still outstanding.
    always_ff @(posedge clk) begin
        if (!reset && imem_rvalid) begin
            assert (r_outstanding != '0);
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module      : tb_instr_fetch_queue
//  Description : Directed self-checking bench for instr_fetch_queue with a
//                variable-latency memory model and a PC scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_queue;

    localparam int              PC_W     = 9;
    localparam int              INS_W    = 32;
    localparam int              DEPTH    = 4;
    localparam logic [PC_W-1:0] RESET_PC = '0;

    logic             clk = 1'b0;
    logic             reset;
    logic             imem_req;
    logic [PC_W-1:0]  imem_addr;
    logic             imem_gnt;
    logic             imem_rvalid;
    logic [INS_W-1:0] imem_rdata;
    logic             instr_valid;
    logic             instr_ready;
    logic [INS_W-1:0] instr;
    logic [PC_W-1:0]  instr_pc;
    logic             redirect;
    logic [PC_W-1:0]  redirect_pc;
    logic [PC_W-1:0]  fetch_pc;

    instr_fetch_queue #(
        .PC_W     (PC_W),
        .INS_W    (INS_W),
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) u_dut (
        .clk         (clk),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .fetch_pc    (fetch_pc)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int lat = 1;
    int grant_cnt = 0;
    int first_hs_cyc = -1;
    int last_hs_cyc = -1;
    int c0;
    bit ready_en = 1'b0;
    logic [PC_W-1:0] exp_addr = '0;
    logic [PC_W-1:0] exp_q[$];
    logic [PC_W-1:0] pend_addr[$];
    int              pend_due[$];

    function automatic logic [INS_W-1:0] mem_word(input logic [PC_W-1:0] a);
        return {16'hC0DE, 7'd0, a};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_ready();
        instr_ready = ready_en && (exp_q.size() > 0);
    endtask

    // One clock: sample/score at negedge, then advance the memory model.
    task automatic step();
        logic            g;
        logic            r;
        logic [PC_W-1:0] a;
        logic [PC_W-1:0] e;
        g = 1'b0;
        r = 1'b0;
        a = '0;
        @(negedge clk);
        if (!reset) begin
            if (instr_valid && instr_ready && !redirect) begin
                if (exp_q.size() == 0) begin
                    check("spurious_instr_valid", instr_valid, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("instr_pc", instr_pc, e);
                    check("instr", instr, mem_word(e));
                    if (first_hs_cyc < 0) first_hs_cyc = cyc;
                    last_hs_cyc = cyc;
                end
            end
            if (imem_req && imem_gnt) begin
                check("imem_addr", imem_addr, exp_addr);
                exp_addr = exp_addr + PC_W'(4);
                grant_cnt++;
                g = 1'b1;
                a = imem_addr;
            end
            r = imem_rvalid;
        end
        @(posedge clk);
        #1;
        cyc++;
        if (reset) begin
            pend_addr.delete();
            pend_due.delete();
        end else begin
            if (r && pend_addr.size() > 0) begin
                void'(pend_addr.pop_front());
                void'(pend_due.pop_front());
            end
            if (g) begin
                pend_addr.push_back(a);
                pend_due.push_back(cyc + lat - 1);
            end
        end
        if (!reset && pend_addr.size() > 0 && pend_due[0] <= cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word(pend_addr[0]);
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = '0;
        end
        drive_ready();
        #1;
    endtask

    task automatic do_reset();
        reset       = 1'b1;
        imem_rvalid = 1'b0;
        redirect    = 1'b0;
        step();
        step();
        reset        = 1'b0;
        exp_q.delete();
        exp_addr     = RESET_PC;
        grant_cnt    = 0;
        first_hs_cyc = -1;
        last_hs_cyc  = -1;
        drive_ready();
        #1;
    endtask

    task automatic push_exp(input logic [PC_W-1:0] pc, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(pc + PC_W'(4 * i));
        drive_ready();
    endtask

    task automatic do_redirect(input logic [PC_W-1:0] pc, input int n);
        redirect    = 1'b1;
        redirect_pc = pc;
        exp_q.delete();
        exp_addr    = pc;
        push_exp(pc, n);
        #1;
        check("redirect_req_low", imem_req, 0);
        step();
        redirect = 1'b0;
        #1;
        check("redirect_first_req", imem_req, 1);
        check("redirect_first_addr", imem_addr, pc);
    endtask

    task automatic drain(input string tag, input int bound);
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < bound) begin
            step();
            n++;
        end
        check(tag, exp_q.size(), 0);
    endtask

    initial begin
        reset       = 1'b1;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        instr_ready = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;
        step();
        step();
        check("reset_imem_req", imem_req, 0);
        check("reset_instr_valid", instr_valid, 0);
        check("reset_fetch_pc", fetch_pc, RESET_PC);

        // 1: streaming with 1-cycle memory
        do_reset();
        imem_gnt = 1'b1; lat = 1; ready_en = 1'b1;
        push_exp(RESET_PC, 8);
        c0 = cyc;
        #1;
        check("t1_first_req", imem_req, 1);
        step();
`ifdef FETCH_BYPASS_EN
        check("t1_bypass_same_cycle", instr_valid, 1);
`else
        check("t1_no_early_valid", instr_valid, 0);
`endif
        drain("t1_drain", 40);
`ifdef FETCH_BYPASS_EN
        check("t1_latency", first_hs_cyc - c0, 1);
`else
        check("t1_latency", first_hs_cyc - c0, 2);
`endif
        check("t1_throughput", last_hs_cyc - first_hs_cyc, 7);

        // 2: back-pressure fills the queue, credits then return
        do_reset();
        imem_gnt = 1'b1; lat = 1; ready_en = 1'b0;
        repeat (10) step();
        check("t2_grant_count", grant_cnt, 4);
        check("t2_req_blocked", imem_req, 0);
        check("t2_full_valid", instr_valid, 1);
        check("t2_head_pc", instr_pc, 9'h000);
        ready_en = 1'b1;
        push_exp(RESET_PC, 6);
        #1;
        check("t2_req_before_pop", imem_req, 0);
        step();
        check("t2_req_after_pop", imem_req, 1);
        check("t2_addr_after_pop", imem_addr, 9'h010);
        drain("t2_drain", 40);

        // 3: redirect with two stale responses in flight
        do_reset();
        imem_gnt = 1'b1; lat = 3; ready_en = 1'b1;
        step();
        step();
        do_redirect(9'h040, 4);
        drain("t3_drain", 40);

        // 4: grant stall holds the address; redirect during the stall
        do_reset();
        imem_gnt = 1'b1; lat = 1; ready_en = 1'b1;
        push_exp(RESET_PC, 3);
        repeat (3) step();
        imem_gnt = 1'b0;
        #1;
        for (int i = 0; i < 5; i++) begin
            check("t4_stall_req", imem_req, 1);
            check("t4_stall_addr", imem_addr, 9'h00C);
            step();
        end
        check("t4_pre_redirect_drained", exp_q.size(), 0);
        do_redirect(9'h080, 2);
        imem_gnt = 1'b1;
        drain("t4_drain", 40);

        // 5: fetch PC wraps at the top of the address space
        do_reset();
        imem_gnt = 1'b1; lat = 1; ready_en = 1'b1;
        do_redirect(9'h1F8, 4);
        drain("t5_drain", 40);
        check("t5_wrapped_grants", grant_cnt >= 3, 1);

        // 6: asynchronous reset in the middle of a burst
        do_reset();
        imem_gnt = 1'b1; lat = 3; ready_en = 1'b0;
        repeat (5) step();
        check("t6_pre_fetch_pc", fetch_pc, 9'h010);
        check("t6_pre_valid", instr_valid, 1);
        reset       = 1'b1;
        imem_rvalid = 1'b0;
        #1;
        check("t6_async_req", imem_req, 0);
        check("t6_async_valid", instr_valid, 0);
        check("t6_async_fetch_pc", fetch_pc, RESET_PC);
        do_reset();
        imem_gnt = 1'b1; lat = 1; ready_en = 1'b1;
        push_exp(RESET_PC, 4);
        #1;
        check("t6_restart_addr", imem_addr, RESET_PC);
        drain("t6_drain", 40);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
